eth_stats_axil_poller: RTL and testbench



---
 rtl/eth_stats_pkg.sv | 29 ++
 rtl/eth_stats_axil_poller_timer.sv | 37 +++
 rtl/eth_stats_axil_poller.sv | 161 ++++++++++++++++
 tb/tb_eth_stats_axil_poller.sv | 511 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_stats_pkg.sv
// Shared types and register map for the Ethernet RX FIFO statistics poller.
package eth_stats_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int NUM_CNT = 3;

  localparam logic [13:0] CORRUPTED_OFS = 14'hC;
  localparam logic [13:0] DROPPED_OFS   = 14'h10;
  localparam logic [13:0] TOTAL_OFS     = 14'h14;

  // Read order of one round; idx walks this table front to back.
  localparam logic [13:0] CNT_OFS [NUM_CNT] = '{CORRUPTED_OFS, DROPPED_OFS, TOTAL_OFS};

  function automatic logic [13:0] cnt_ofs(input logic [1:0] idx);
    case (idx)
      2'd0:    return CNT_OFS[0];
      2'd1:    return CNT_OFS[1];
      2'd2:    return CNT_OFS[2];
      default: return 14'h0;
    endcase
  endfunction

endpackage

// File: rtl/eth_stats_axil_poller_timer.sv
// Poll period timer: counts down from PERIOD-1 while enabled, one-cycle expire pulse at zero.
module eth_stats_period_timer #(
  parameter logic [31:0] PERIOD = 32'd1_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [31:0] RELOAD = PERIOD - 32'd1;

  logic [31:0] count_q, count_d;

  // Disabling parks the counter at reload so a fresh enable always waits a full period.
  always_comb begin
    count_d  = count_q;
    expire_o = 1'b0;
    if (!enable_i) begin
      count_d = RELOAD;
    end else if (count_q == 32'd0) begin
      count_d  = RELOAD;
      expire_o = 1'b1;
    end else begin
      count_d = count_q - 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= RELOAD;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/eth_stats_axil_poller.sv
// AXI4-Lite read initiator that snapshots the RX FIFO corrupted/dropped/total counters.
// Define ETH_STATS_DELTA_EN to build the per-round delta outputs; otherwise they read 0.
module eth_stats_axil_poller
  import eth_stats_pkg::*;
#(
  parameter logic [13:0] BASE_ADDR   = 14'h0000,
  parameter logic [31:0] POLL_PERIOD = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        trigger,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  output logic [13:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  output logic        busy,
  output logic        snap_valid,
  output logic        snap_err,
  output logic [31:0] corrupted_cnt,
  output logic [31:0] dropped_cnt,
  output logic [31:0] total_cnt,
  output logic [31:0] corrupted_dlt,
  output logic [31:0] dropped_dlt,
  output logic [31:0] total_dlt,
  output logic [1:0]  dbg_state_o
);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        pending_q, pending_d;
  logic        round_err_q, round_err_d;
  logic        snap_valid_q;
  logic        snap_err_q;
  logic [31:0] shadow_q [NUM_CNT];
  logic [31:0] cnt_q    [NUM_CNT];
  logic        shadow_we;
  logic        publish;
  logic        expire;

  eth_stats_period_timer #(
    .PERIOD (POLL_PERIOD)
  ) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .enable_i (enable),
    .expire_o (expire)
  );

  // Handshakes: a beat moves on any rising clk where valid && ready; arvalid holds with a
  // stable araddr until accepted, and only one read is ever outstanding (AR and R never overlap).
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pending_d   = pending_q | expire | trigger;
    round_err_d = round_err_q;
    shadow_we   = 1'b0;
    publish     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          pending_d   = expire | trigger;
          idx_d       = 2'd0;
          round_err_d = 1'b0;
          state_d     = ST_AR;
        end
      end
      ST_AR: begin
        if (m_axi_arready) state_d = ST_R;
      end
      ST_R: begin
        if (m_axi_rvalid) begin
          shadow_we   = 1'b1;
          round_err_d = round_err_q | (m_axi_rresp != 2'b00);
          if (idx_q == 2'(NUM_CNT - 1)) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_AR;
          end
        end
      end
      ST_DONE: begin
        publish = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      pending_q   <= 1'b0;
      round_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pending_q   <= pending_d;
      round_err_q <= round_err_d;
    end
  end

  // Shadows collect one round; the visible counters only move together in DONE.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      snap_valid_q <= 1'b0;
      snap_err_q   <= 1'b0;
      for (int i = 0; i < NUM_CNT; i++) begin
        shadow_q[i] <= 32'd0;
        cnt_q[i]    <= 32'd0;
      end
    end else begin
      snap_valid_q <= publish;
      if (shadow_we) shadow_q[idx_q] <= m_axi_rdata;
      if (publish) begin
        snap_err_q <= round_err_q;
        for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= shadow_q[i];
      end
    end
  end

`ifdef ETH_STATS_DELTA_EN
  logic [31:0] dlt_q [NUM_CNT];

  // Modulo-2^32 subtraction makes a counter wrap still read as a small positive delta.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CNT; i++) dlt_q[i] <= 32'd0;
    end else if (publish) begin
      for (int i = 0; i < NUM_CNT; i++) dlt_q[i] <= shadow_q[i] - cnt_q[i];
    end
  end

  assign corrupted_dlt = dlt_q[0];
  assign dropped_dlt   = dlt_q[1];
  assign total_dlt     = dlt_q[2];
`else
  assign corrupted_dlt = 32'd0;
  assign dropped_dlt   = 32'd0;
  assign total_dlt     = 32'd0;
`endif

  assign m_axi_arvalid = (state_q == ST_AR);
  assign m_axi_araddr  = (state_q == ST_AR) ? (BASE_ADDR + cnt_ofs(idx_q)) : 14'h0;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_rready  = (state_q == ST_R);
  assign busy          = (state_q != ST_IDLE);
  assign snap_valid    = snap_valid_q;
  assign snap_err      = snap_err_q;
  assign corrupted_cnt = cnt_q[0];
  assign dropped_cnt   = cnt_q[1];
  assign total_cnt     = cnt_q[2];
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_eth_stats_axil_poller.sv
// Self-checking bench for eth_stats_axil_poller with an AXI4-Lite read responder and snapshot scoreboard.
`timescale 1ns/1ps
module tb_eth_stats_axil_poller;
  import eth_stats_pkg::*;

  localparam logic [13:0] BASE   = 14'h0100;
  localparam logic [31:0] PERIOD = 32'd8;
  localparam int          R_LAT  = 3;
  localparam int          SW     = 32 * 6 + 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        trigger = 1'b0;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [13:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'b00;
  logic        busy, snap_valid, snap_err;
  logic [31:0] cc, dc, tc, cd, dd, td;
  logic [1:0]  dbg_state;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          stall;
  } rsp_t;

  rsp_t              rsp_q[$];
  logic [SW-1:0]     exp_q[$];
  logic [13:0]       ar_log[$];
  logic [31:0]       prev_model [3];

  int n_cmp = 0;
  int n_err = 0;
  int snaps = 0;
  int proto_err = 0;
  int addr_unstable = 0;
  int stall_seen = 0;

  eth_stats_axil_poller #(
    .BASE_ADDR   (BASE),
    .POLL_PERIOD (PERIOD)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .enable        (enable),
    .trigger       (trigger),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (arready),
    .m_axi_araddr  (araddr),
    .m_axi_arprot  (arprot),
    .m_axi_rvalid  (rvalid),
    .m_axi_rready  (rready),
    .m_axi_rdata   (rdata),
    .m_axi_rresp   (rresp),
    .busy          (busy),
    .snap_valid    (snap_valid),
    .snap_err      (snap_err),
    .corrupted_cnt (cc),
    .dropped_cnt   (dc),
    .total_cnt     (tc),
    .corrupted_dlt (cd),
    .dropped_dlt   (dd),
    .total_dlt     (td),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1ms, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- responder ----------------
  // Acks AR after the entry's stall count, then returns rvalid R_LAT cycles after the handshake.
  int          rs_state = 0;
  int          rs_wait = 0;
  int          rs_stall = 0;
  bit          rs_fresh = 1'b1;
  logic [13:0] rs_addr;
  rsp_t        cur;

  always @(negedge clk) begin
    if (!rstn) begin
      arready  = 1'b0;
      rvalid   = 1'b0;
      rs_state = 0;
      rs_fresh = 1'b1;
    end else begin
      if (rs_state == 3) begin
        rvalid   = 1'b0;
        rs_state = 0;
      end
      if (rs_state == 0) begin
        if (arvalid) begin
          if (rs_fresh) begin
            if (rsp_q.size() > 0) cur = rsp_q.pop_front();
            else begin cur.data = 32'hDEAD_0000; cur.resp = 2'b00; cur.stall = 0; end
            rs_stall = cur.stall;
            rs_addr  = araddr;
            rs_fresh = 1'b0;
          end else if (araddr !== rs_addr) begin
            addr_unstable++;
          end
          if (rs_stall > 0) begin
            rs_stall--;
            stall_seen++;
            arready = 1'b0;
          end else begin
            arready  = 1'b1;
            rs_state = 1;
            rs_fresh = 1'b1;
          end
        end
      end else if (rs_state == 1) begin
        arready = 1'b0;
        if (arvalid) proto_err++;
        ar_log.push_back(rs_addr);
        rs_wait  = R_LAT - 1;
        rs_state = 2;
      end else if (rs_state == 2) begin
        if (arvalid) proto_err++;
        rs_wait--;
        if (rs_wait == 0) begin
          rvalid   = 1'b1;
          rdata    = cur.data;
          rresp    = cur.resp;
          rs_state = 3;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [SW-1:0] exp_v;

  always @(negedge clk) begin
    if (rstn) begin
      if (arvalid && rready) proto_err++;
      if (snap_valid) begin
        snaps++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL snap_unexpected: got snapshot total=%h, required no snapshot", tc);
        end else begin
          exp_v = exp_q.pop_front();
          if (snap_err !== exp_v[192]) begin
            n_err++;
            $display("FAIL snap_err: got %b, required %b", snap_err, exp_v[192]);
          end
          n_cmp++;
          if ({cc, dc, tc} !== exp_v[191:96]) begin
            n_err++;
            $display("FAIL snap_cnt: got %h/%h/%h, required %h/%h/%h", cc, dc, tc,
                     exp_v[191:160], exp_v[159:128], exp_v[127:96]);
          end
          n_cmp++;
          if ({cd, dd, td} !== exp_v[95:0]) begin
            n_err++;
            $display("FAIL snap_dlt: got %h/%h/%h, required %h/%h/%h", cd, dd, td,
                     exp_v[95:64], exp_v[63:32], exp_v[31:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_round(input logic [31:0] c, input logic [31:0] d, input logic [31:0] t,
                            input logic [1:0] r1, input int stall1);
    rsp_t        e;
    logic [31:0] v [3];
    logic [31:0] dl [3];
    v = '{c, d, t};
    for (int i = 0; i < 3; i++) begin
      e.data  = v[i];
      e.resp  = (i == 1) ? r1 : 2'b00;
      e.stall = (i == 1) ? stall1 : 0;
      rsp_q.push_back(e);
`ifdef ETH_STATS_DELTA_EN
      dl[i] = v[i] - prev_model[i];
`else
      dl[i] = 32'd0;
`endif
      prev_model[i] = v[i];
    end
    exp_q.push_back({(r1 != 2'b00), c, d, t, dl[0], dl[1], dl[2]});
  endtask

  task automatic pulse_trigger();
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic wait_snaps(input int target, input int budget, output bit ok);
    int n;
    n = 0;
    while (snaps < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (snaps >= target);
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rsp_q.delete();
    exp_q.delete();
    prev_model = '{32'd0, 32'd0, 32'd0};
    rstn = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_cmp++;
    if ({arvalid, rready, busy, snap_valid, snap_err} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got arv/rr/busy/sv/se=%b, required 00000",
               {arvalid, rready, busy, snap_valid, snap_err});
    end
    n_cmp++;
    if ({cc, dc, tc, cd, dd, td} !== 192'd0) begin
      n_err++;
      $display("FAIL reset_data: got %h %h %h %h %h %h, required all zero", cc, dc, tc, cd, dd, td);
    end
    n_cmp++;
    if ({araddr, arprot} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_addr: got araddr=%h arprot=%b, required 0", araddr, arprot);
    end
    n_cmp++;
    if (dbg_state !== 2'(ST_IDLE)) begin
      n_err++;
      $display("FAIL reset_state: got %0d, required %0d", dbg_state, 2'(ST_IDLE));
    end
  endtask

  task automatic test_basic_round();
    int base;
    int lat;
    bit ok;
    base = snaps;
    ar_log.delete();
    push_round(32'd5, 32'd7, 32'd100, 2'b00, 0);
    pulse_trigger();
    n_cmp++;
    if (arvalid !== 1'b0) begin
      n_err++;
      $display("FAIL trig_t1_arvalid: got %b, required 0 one cycle after trigger", arvalid);
    end
    @(negedge clk);
    n_cmp++;
    if ({arvalid, busy, arprot} !== 5'b11000) begin
      n_err++;
      $display("FAIL trig_t2: got arvalid=%b busy=%b arprot=%b, required 1 1 000", arvalid, busy, arprot);
    end
    lat = 0;
    while (snap_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat != 3 * (1 + R_LAT) + 1) begin
      n_err++;
      $display("FAIL round_latency: got %0d cycles, required %0d", lat, 3 * (1 + R_LAT) + 1);
    end
    wait_snaps(base + 1, 100, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL basic_timeout: got %0d snapshots, required %0d", snaps - base, 1);
    end
    @(negedge clk);
    n_cmp++;
    if (ar_log.size() != 3) begin
      n_err++;
      $display("FAIL basic_ar_count: got %0d reads, required 3", ar_log.size());
    end else if ({ar_log[0], ar_log[1], ar_log[2]} !== {BASE + 14'hC, BASE + 14'h10, BASE + 14'h14}) begin
      n_err++;
      $display("FAIL basic_ar_order: got %h %h %h, required %h %h %h", ar_log[0], ar_log[1], ar_log[2],
               BASE + 14'hC, BASE + 14'h10, BASE + 14'h14);
    end
    n_cmp++;
    if ({busy, snap_valid, cc, dc, tc} !== {2'b00, 32'd5, 32'd7, 32'd100}) begin
      n_err++;
      $display("FAIL basic_hold: got busy=%b sv=%b %0d/%0d/%0d, required 0 0 5/7/100",
               busy, snap_valid, cc, dc, tc);
    end
  endtask

  task automatic test_error_resp();
    bit ok;
    int base;
    base = snaps;
    push_round(32'd11, 32'd22, 32'd33, 2'b10, 0);
    pulse_trigger();
    wait_snaps(base + 1, 100, ok);
    @(negedge clk);
    n_cmp++;
    if (!ok || snap_err !== 1'b1 || dc !== 32'd22) begin
      n_err++;
      $display("FAIL err_round: got ok=%b snap_err=%b dropped=%0d, required 1 1 22", ok, snap_err, dc);
    end
    push_round(32'd44, 32'd55, 32'd66, 2'b00, 0);
    pulse_trigger();
    wait_snaps(base + 2, 100, ok);
    @(negedge clk);
    n_cmp++;
    if (!ok || snap_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_clear: got ok=%b snap_err=%b, required 1 0", ok, snap_err);
    end
  endtask

  task automatic test_ar_stall();
    bit ok;
    int base;
    base = snaps;
    ar_log.delete();
    stall_seen    = 0;
    addr_unstable = 0;
    push_round(32'd1, 32'd2, 32'd3, 2'b00, 20);
    pulse_trigger();
    wait_snaps(base + 1, 200, ok);
    n_cmp++;
    if (!ok || stall_seen != 20) begin
      n_err++;
      $display("FAIL stall_len: got ok=%b stalled=%0d, required 1 20", ok, stall_seen);
    end
    n_cmp++;
    if (addr_unstable != 0) begin
      n_err++;
      $display("FAIL stall_addr: got %0d address changes, required 0", addr_unstable);
    end
    n_cmp++;
    if (ar_log.size() != 3 || ar_log[1] !== BASE + 14'h10) begin
      n_err++;
      $display("FAIL stall_ar: got %0d reads, second=%h, required 3 and %h", ar_log.size(),
               (ar_log.size() > 1) ? ar_log[1] : 14'h0, BASE + 14'h10);
    end
  endtask

  task automatic test_coalesce();
    bit ok;
    int base;
    base = snaps;
    push_round(32'd1000, 32'd2000, 32'd3000, 2'b00, 0);
    push_round(32'd1001, 32'd2001, 32'd3001, 2'b00, 0);
    pulse_trigger();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) pulse_trigger();
    wait_snaps(base + 2, 200, ok);
    repeat (60) @(negedge clk);
    n_cmp++;
    if (snaps - base != 2 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL coalesce_rounds: got %0d rounds busy=%b, required 2 rounds busy=0", snaps - base, busy);
    end
    n_cmp++;
    if (exp_q.size() != 0 || rsp_q.size() != 0) begin
      n_err++;
      $display("FAIL coalesce_queues: got exp=%0d rsp=%0d left, required 0 0", exp_q.size(), rsp_q.size());
    end
  endtask

  task automatic test_timer();
    int base;
    int n;
    base = snaps;
    for (int k = 0; k < 8; k++) push_round(32'(100 + k), 32'(200 + k), 32'(300 + k), 2'b00, 0);
    @(negedge clk);
    enable = 1'b1;
    repeat (80) @(negedge clk);
    pulse_trigger();
    repeat (20) @(negedge clk);
    enable = 1'b0;
    repeat (60) @(negedge clk);
    n = snaps - base;
    n_cmp++;
    if (n < 4 || n > 8 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL timer_rounds: got %0d rounds busy=%b, required 4..8 and idle", n, busy);
    end
    n_cmp++;
    if (rsp_q.size() != 3 * (8 - n) || exp_q.size() != 8 - n) begin
      n_err++;
      $display("FAIL timer_queues: got rsp=%0d exp=%0d, required %0d %0d", rsp_q.size(), exp_q.size(),
               3 * (8 - n), 8 - n);
    end
    rsp_q.delete();
    exp_q.delete();
    if (n > 0) prev_model = '{32'(100 + n - 1), 32'(200 + n - 1), 32'(300 + n - 1)};
  endtask

  task automatic test_delta();
    bit ok;
    int base;
    logic [31:0] want;
    base = snaps;
    push_round(32'd9, 32'd9, 32'hFFFF_FFF0, 2'b00, 0);
    pulse_trigger();
    wait_snaps(base + 1, 100, ok);
    push_round(32'd9, 32'd9, 32'h0000_0010, 2'b00, 0);
    pulse_trigger();
    wait_snaps(base + 2, 100, ok);
    @(negedge clk);
`ifdef ETH_STATS_DELTA_EN
    want = 32'h20;
`else
    want = 32'h0;
`endif
    n_cmp++;
    if (!ok || td !== want || tc !== 32'h10) begin
      n_err++;
      $display("FAIL delta_wrap: got ok=%b total=%h total_dlt=%h, required 1 00000010 %h", ok, tc, td, want);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base;
    int n;
    logic [31:0] want;
    base = snaps;
    push_round(32'd77, 32'd88, 32'd99, 2'b00, 0);
    pulse_trigger();
    n = 0;
    while (dbg_state !== 2'(ST_R) && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (dbg_state !== 2'(ST_R)) begin
      n_err++;
      $display("FAIL midrst_reach: got state %0d, required %0d", dbg_state, 2'(ST_R));
    end
    rstn = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({arvalid, rready, busy, snap_valid, snap_err, cc, dc, tc, cd, dd, td} !== 197'd0 ||
        dbg_state !== 2'(ST_IDLE)) begin
      n_err++;
      $display("FAIL midrst_outputs: got ctrl=%b cnt=%h/%h/%h state=%0d, required all 0 and IDLE",
               {arvalid, rready, busy, snap_valid, snap_err}, cc, dc, tc, dbg_state);
    end
    @(negedge clk);
    rsp_q.delete();
    exp_q.delete();
    prev_model = '{32'd0, 32'd0, 32'd0};
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (snaps != base || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_nopulse: got %0d snapshots busy=%b, required 0 and 0", snaps - base, busy);
    end
    push_round(32'd3, 32'd4, 32'd5, 2'b00, 0);
    pulse_trigger();
    wait_snaps(base + 1, 100, ok);
    @(negedge clk);
`ifdef ETH_STATS_DELTA_EN
    want = 32'd5;
`else
    want = 32'd0;
`endif
    n_cmp++;
    if (!ok || tc !== 32'd5 || td !== want) begin
      n_err++;
      $display("FAIL midrst_recover: got ok=%b total=%0d total_dlt=%0d, required 1 5 %0d", ok, tc, td, want);
    end
  endtask

  task automatic test_protocol();
    n_cmp++;
    if (proto_err != 0) begin
      n_err++;
      $display("FAIL axi_protocol: got %0d overlap/extra-arvalid events, required 0", proto_err);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    prev_model = '{32'd0, 32'd0, 32'd0};
    apply_reset();
    test_reset();
    test_basic_round();
    test_error_resp();
    test_ar_stall();
    test_coalesce();
    test_timer();
    test_delta();
    test_reset_mid();
    test_protocol();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
